// File: rtl/day11_pkg.sv
// rtl/day11_pkg.sv - shared types and constants for the day-11 path counter
package day11_pkg;

    localparam int MAX_NODES   = 1024;
    localparam int NODE_WIDTH  = $clog2(MAX_NODES);
    localparam int COUNT_WIDTH = 16;

    typedef logic [NODE_WIDTH-1:0] node_t;

    localparam node_t NODE_NULL = '1;

    typedef enum logic [3:0] {
        ST_CLEAR,
        ST_INGEST,
        ST_POP,
        ST_FETCH,
        ST_EVAL,
        ST_QUERY,
        ST_REPLY,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - generic simple dual-port RAM, one write port, registered read
module sdp_ram #(
    parameter int DEPTH      = 1024,
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/path_count_dp.sv
// rtl/path_count_dp.sv - counts start-to-end paths over a topologically sorted node stream
module path_count_dp #(
    parameter int MAX_NODES   = day11_pkg::MAX_NODES,
    parameter int NODE_WIDTH  = $clog2(MAX_NODES),
    parameter int COUNT_WIDTH = day11_pkg::COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NODE_WIDTH-1:0]  start_node,
    input  logic [NODE_WIDTH-1:0]  end_node,
    input  logic                   sorted_valid,
    input  logic [NODE_WIDTH-1:0]  sorted_node,
    input  logic                   sorted_last,
    input  logic                   query_ready,
    output logic                   query_valid,
    output logic [NODE_WIDTH-1:0]  query_data,
    output logic                   reply_ready,
    input  logic                   reply_valid,
    input  logic                   reply_last,
    input  logic [NODE_WIDTH-1:0]  reply_data,
    output logic                   port_owned,
    output logic                   result_valid,
    output logic [COUNT_WIDTH-1:0] result
);

    import day11_pkg::*;

    localparam int                    PW        = NODE_WIDTH + 1;
    localparam logic [PW-1:0]         PTR_FULL  = PW'(MAX_NODES);
    localparam logic [NODE_WIDTH-1:0] NULL_ID   = '1;
    localparam logic [NODE_WIDTH-1:0] LAST_ADDR = NODE_WIDTH'(MAX_NODES - 1);

    state_t                 state;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          rd_next;
    logic                   last_seen;
    logic [NODE_WIDTH-1:0]  clr_addr;
    logic [NODE_WIDTH-1:0]  node_q;
    logic [NODE_WIDTH-1:0]  dst_q;
    logic                   dst_last;
    logic [COUNT_WIDTH-1:0] node_cnt;

    logic                   ord_we;
    logic [NODE_WIDTH-1:0]  ord_raddr;
    logic [NODE_WIDTH-1:0]  ord_rdata;
    logic                   cnt_we;
    logic [NODE_WIDTH-1:0]  cnt_waddr;
    logic [COUNT_WIDTH-1:0] cnt_wdata;
    logic [NODE_WIDTH-1:0]  cnt_raddr;
    logic [COUNT_WIDTH-1:0] cnt_rdata;

    assign rd_next = rd_ptr + PW'(1);
    assign ord_we  = sorted_valid && !last_seen && (state != ST_DONE) && (wr_ptr != PTR_FULL);

    // A zero-count node prefetches the next order entry from EVAL, so skipping costs two cycles.
    assign ord_raddr = (state == ST_EVAL) ? rd_next[NODE_WIDTH-1:0] : rd_ptr[NODE_WIDTH-1:0];
    assign cnt_raddr = (state == ST_FETCH) ? ord_rdata : dst_q;

    always_comb begin
        cnt_we    = 1'b0;
        cnt_waddr = clr_addr;
        cnt_wdata = '0;
        case (state)
            ST_CLEAR: begin
                cnt_we = 1'b1;
            end
            ST_INGEST: begin
                if (last_seen) begin
                    cnt_we    = 1'b1;
                    cnt_waddr = start_node;
                    cnt_wdata = COUNT_WIDTH'(1);
                end
            end
            ST_RMW_WR: begin
                cnt_we    = 1'b1;
                cnt_waddr = dst_q;
                cnt_wdata = cnt_rdata + node_cnt;
            end
            default: begin
            end
        endcase
    end

    sdp_ram #(
        .DEPTH (MAX_NODES),
        .WIDTH (NODE_WIDTH)
    ) u_order_buf (
        .clk     (clk),
        .wr_en   (ord_we),
        .wr_addr (wr_ptr[NODE_WIDTH-1:0]),
        .wr_data (sorted_node),
        .rd_addr (ord_raddr),
        .rd_data (ord_rdata)
    );

    sdp_ram #(
        .DEPTH (MAX_NODES),
        .WIDTH (COUNT_WIDTH)
    ) u_count_ram (
        .clk     (clk),
        .wr_en   (cnt_we),
        .wr_addr (cnt_waddr),
        .wr_data (cnt_wdata),
        .rd_addr (cnt_raddr),
        .rd_data (cnt_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            last_seen <= 1'b0;
        end else if (sorted_valid && !last_seen && (state != ST_DONE)) begin
            if (wr_ptr != PTR_FULL) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (sorted_last) begin
                last_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_CLEAR;
            clr_addr     <= '0;
            rd_ptr       <= '0;
            node_q       <= '0;
            dst_q        <= '0;
            dst_last     <= 1'b0;
            node_cnt     <= '0;
            query_valid  <= 1'b0;
            query_data   <= '0;
            reply_ready  <= 1'b0;
            port_owned   <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_addr <= clr_addr + NODE_WIDTH'(1);
                    if (clr_addr == LAST_ADDR) begin
                        state <= ST_INGEST;
                    end
                end
                ST_INGEST: begin
                    if (last_seen) begin
                        rd_ptr     <= '0;
                        port_owned <= 1'b1;
                        state      <= ST_POP;
                    end
                end
                ST_POP: begin
                    if (rd_ptr == wr_ptr) begin
                        result       <= '0;
                        result_valid <= 1'b1;
                        port_owned   <= 1'b0;
                        state        <= ST_DONE;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    node_q <= ord_rdata;
                    state  <= ST_EVAL;
                end
                ST_EVAL: begin
                    if (node_q == end_node) begin
                        result       <= cnt_rdata;
                        result_valid <= 1'b1;
                        port_owned   <= 1'b0;
                        state        <= ST_DONE;
                    end else if (cnt_rdata == '0) begin
                        rd_ptr <= rd_next;
                        if (rd_next == wr_ptr) begin
                            result       <= '0;
                            result_valid <= 1'b1;
                            port_owned   <= 1'b0;
                            state        <= ST_DONE;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end else begin
                        node_cnt    <= cnt_rdata;
                        query_valid <= 1'b1;
                        query_data  <= node_q;
                        state       <= ST_QUERY;
                    end
                end
                ST_QUERY: begin
                    if (query_ready) begin
                        query_valid <= 1'b0;
                        reply_ready <= 1'b1;
                        state       <= ST_REPLY;
                    end
                end
                ST_REPLY: begin
                    if (reply_valid) begin
                        if (reply_data == NULL_ID) begin
                            if (reply_last) begin
                                reply_ready <= 1'b0;
                                rd_ptr      <= rd_next;
                                state       <= ST_POP;
                            end
                        end else begin
                            dst_q       <= reply_data;
                            dst_last    <= reply_last;
                            reply_ready <= 1'b0;
                            state       <= ST_RMW_RD;
                        end
                    end
                end
                ST_RMW_RD: begin
                    state <= ST_RMW_WR;
                end
                ST_RMW_WR: begin
                    if (dst_last) begin
                        rd_ptr <= rd_next;
                        state  <= ST_POP;
                    end else begin
                        reply_ready <= 1'b1;
                        state       <= ST_REPLY;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_path_count_dp.sv
// tb/tb_path_count_dp.sv - randomized scoreboard bench for path_count_dp
`timescale 1ns/1ps
module tb_path_count_dp;

    localparam int NW   = 10;
    localparam int NN   = 32;
    localparam int MAXE = 20;
    localparam logic [NW-1:0] NULLN = '1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          sel4;
    logic [NW-1:0] start_node, end_node, sorted_node, reply_data;
    logic          sorted_valid, sorted_last;
    logic          query_ready, reply_valid, reply_last;

    logic          qv_a, rr_a, po_a, rv_a;
    logic [NW-1:0] qd_a;
    logic [15:0]   res_a;
    logic          qv_b, rr_b, po_b, rv_b;
    logic [NW-1:0] qd_b;
    logic [3:0]    res_b;

    logic          qv_m, rr_m, po_m, rv_m;
    logic [NW-1:0] qd_m;
    logic [15:0]   res_m;

    assign qv_m  = sel4 ? qv_b : qv_a;
    assign rr_m  = sel4 ? rr_b : rr_a;
    assign po_m  = sel4 ? po_b : po_a;
    assign rv_m  = sel4 ? rv_b : rv_a;
    assign qd_m  = sel4 ? qd_b : qd_a;
    assign res_m = sel4 ? {12'd0, res_b} : res_a;

    path_count_dp dut_a (
        .clk(clk), .rst_n(rst_n), .start_node(start_node), .end_node(end_node),
        .sorted_valid(sorted_valid), .sorted_node(sorted_node), .sorted_last(sorted_last),
        .query_ready(query_ready & ~sel4), .query_valid(qv_a), .query_data(qd_a),
        .reply_ready(rr_a), .reply_valid(reply_valid & ~sel4), .reply_last(reply_last),
        .reply_data(reply_data), .port_owned(po_a), .result_valid(rv_a), .result(res_a)
    );

    path_count_dp #(.COUNT_WIDTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_node(start_node), .end_node(end_node),
        .sorted_valid(sorted_valid), .sorted_node(sorted_node), .sorted_last(sorted_last),
        .query_ready(query_ready & sel4), .query_valid(qv_b), .query_data(qd_b),
        .reply_ready(rr_b), .reply_valid(reply_valid & sel4), .reply_last(reply_last),
        .reply_data(reply_data), .port_owned(po_b), .result_valid(rv_b), .result(res_b)
    );

    int n_vec  = 0;
    int n_fail = 0;

    int     adj_n [NN];
    int     adj   [NN][MAXE];
    int     order_q[$];
    int     s_node, e_node;
    longint exp_res_q[$];
    int     exp_qry_q[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_graph();
        for (int i = 0; i < NN; i++) adj_n[i] = 0;
        order_q.delete();
    endtask

    task automatic add_edge(input int a, input int b);
        adj[a][adj_n[a]] = b;
        adj_n[a]++;
    endtask

    // Reference: path counts propagated along the sorted order, modulo 2^w.
    task automatic model_push(input int w, output longint res);
        longint cnt [NN];
        longint mask;
        int     n;
        mask = (64'd1 << w) - 1;
        for (int i = 0; i < NN; i++) cnt[i] = 0;
        cnt[s_node] = 1;
        res = 0;
        for (int k = 0; k < order_q.size(); k++) begin
            n = order_q[k];
            if (n == e_node) begin
                res = cnt[n];
                break;
            end
            if (cnt[n] != 0) begin
                exp_qry_q.push_back(n);
                for (int j = 0; j < adj_n[n]; j++)
                    cnt[adj[n][j]] = (cnt[adj[n][j]] + cnt[n]) & mask;
            end
        end
        exp_res_q.push_back(res);
    endtask

    // Adjacency-map responder with random stalls on both handshakes.
    initial begin
        int node, nb;
        query_ready = 1'b0;
        reply_valid = 1'b0;
        reply_last  = 1'b0;
        reply_data  = '0;
        forever begin
            @(negedge clk);
            query_ready = ($urandom_range(0, 2) != 0);
            if (rst_n && qv_m && query_ready) begin
                node = int'(qd_m);
                nb   = (adj_n[node] == 0) ? 1 : adj_n[node];
                @(negedge clk);
                query_ready = 1'b0;
                for (int i = 0; i < nb && rst_n; i++) begin
                    reply_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    reply_valid = 1'b1;
                    reply_data  = (adj_n[node] == 0) ? NULLN : NW'(adj[node][i]);
                    reply_last  = (i == nb - 1);
                    for (int t = 0; t < 200 && rst_n; t++) begin
                        if (rr_m) begin
                            @(negedge clk);
                            break;
                        end
                        @(negedge clk);
                    end
                end
                reply_valid = 1'b0;
                reply_last  = 1'b0;
            end
        end
    end

    // Query monitor.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && qv_m && query_ready) begin
                if (exp_qry_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL query_extra: got query for node %0d, expected none", qd_m);
                end else begin
                    check("query_node", qd_m, exp_qry_q.pop_front());
                end
            end
        end
    end

    // Result monitor.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rv_m && !prev) begin
                if (exp_res_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL result_extra: got result %0d, expected none", res_m);
                end else begin
                    check("result", res_m, exp_res_q.pop_front());
                end
            end
            prev = rv_m;
        end
    end

    task automatic do_reset(input string name);
        rst_n        = 1'b0;
        sorted_valid = 1'b0;
        sorted_last  = 1'b0;
        sorted_node  = '0;
        repeat (2) @(negedge clk);
        exp_res_q.delete();
        exp_qry_q.delete();
        check({name, "_rst_qv"},  qv_m, 0);
        check({name, "_rst_qd"},  qd_m, 0);
        check({name, "_rst_rr"},  rr_m, 0);
        check({name, "_rst_po"},  po_m, 0);
        check({name, "_rst_rv"},  rv_m, 0);
        check({name, "_rst_res"}, res_m, 0);
    endtask

    task automatic start_run(input string name, input int s, input int e, input bit narrow,
                             output longint res);
        sel4       = narrow;
        s_node     = s;
        e_node     = e;
        start_node = NW'(s);
        end_node   = NW'(e);
        do_reset(name);
        model_push(narrow ? 4 : 16, res);
        rst_n = 1'b1;
        for (int k = 0; k < order_q.size(); k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            sorted_valid = 1'b1;
            sorted_node  = NW'(order_q[k]);
            sorted_last  = (k == order_q.size() - 1);
            @(negedge clk);
            sorted_valid = 1'b0;
            sorted_last  = 1'b0;
        end
        // A beat after the last one must be ignored.
        sorted_valid = 1'b1;
        sorted_node  = NW'(e);
        sorted_last  = 1'b1;
        @(negedge clk);
        sorted_valid = 1'b0;
        sorted_last  = 1'b0;
    endtask

    task automatic run(input string name, input int s, input int e, input bit narrow);
        longint res;
        int     cyc;
        start_run(name, s, e, narrow, res);
        cyc = 0;
        while (!rv_m && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        #3;
        if (!rv_m) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s_timeout: result_valid low after %0d cycles, expected high", name, cyc);
        end
        repeat (5) @(negedge clk);
        #3;
        check({name, "_sticky"}, rv_m, 1);
        check({name, "_hold"},   res_m, res);
        check({name, "_owned"},  po_m, 0);
        check({name, "_qleft"},  exp_qry_q.size(), 0);
        check({name, "_rleft"},  exp_res_q.size(), 0);
    endtask

    task automatic diamond();
        clear_graph();
        order_q = '{0, 1, 2, 3};
        add_edge(0, 1); add_edge(0, 2); add_edge(1, 3); add_edge(2, 3);
    endtask

    task automatic random_dag(input int n, output int s, output int e);
        int perm [NN];
        int j, tmp;
        clear_graph();
        for (int i = 0; i < NN; i++) perm[i] = i;
        for (int i = n - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        for (int i = 0; i < n; i++) order_q.push_back(perm[i]);
        for (int i = 0; i < n; i++)
            for (int k = i + 1; k < n; k++)
                if ($urandom_range(0, 99) < 40 && adj_n[perm[i]] < MAXE)
                    add_edge(perm[i], perm[k]);
        s = perm[$urandom_range(0, 2)];
        e = perm[$urandom_range(n - 4, n - 1)];
    endtask

    initial begin
        longint res;
        int     cyc, s, e;
        rst_n        = 1'b0;
        sel4         = 1'b0;
        start_node   = '0;
        end_node     = '0;
        sorted_valid = 1'b0;
        sorted_last  = 1'b0;
        sorted_node  = '0;

        diamond();
        run("diamond", 0, 3, 1'b0);

        // you=1 ... out=10
        clear_graph();
        order_q = '{0, 1, 8, 2, 3, 4, 5, 6, 7, 9, 10};
        add_edge(0, 1); add_edge(0, 8);
        add_edge(1, 2); add_edge(1, 3);
        add_edge(2, 4); add_edge(2, 5);
        add_edge(3, 4); add_edge(3, 5); add_edge(3, 6);
        add_edge(4, 7); add_edge(5, 10); add_edge(6, 10); add_edge(7, 10);
        add_edge(8, 3); add_edge(8, 6); add_edge(8, 9); add_edge(9, 10);
        run("aoc", 1, 10, 1'b0);

        clear_graph();
        order_q = '{3, 0, 1, 2};
        add_edge(0, 1); add_edge(1, 2);
        run("unreachable", 0, 3, 1'b0);

        clear_graph();
        order_q = '{0, 1, 2};
        add_edge(0, 1); add_edge(1, 2);
        run("absent", 0, 7, 1'b0);

        clear_graph();
        order_q = '{0, 1, 2};
        add_edge(0, 1); add_edge(0, 1); add_edge(1, 2);
        run("dup_edge", 0, 2, 1'b0);

        clear_graph();
        order_q = '{0, 1, 2, 3};
        add_edge(0, 1); add_edge(0, 2); add_edge(2, 3);
        run("null_reply", 0, 3, 1'b0);

        clear_graph();
        order_q = '{2, 5, 7};
        add_edge(2, 7); add_edge(5, 7);
        run("start_eq_end", 5, 5, 1'b0);

        clear_graph();
        order_q = '{0, 1, 2};
        for (int i = 0; i < 17; i++) add_edge(0, 1);
        add_edge(1, 2);
        run("wrap4", 0, 1, 1'b1);

        for (int r = 0; r < 3; r++) begin
            random_dag(12, s, e);
            run($sformatf("rand%0d", r), s, e, 1'b0);
        end

        diamond();
        start_run("rst_reply", 0, 3, 1'b0, res);
        cyc = 0;
        while (!rr_m && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_reply", rr_m, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_qv",  qv_m, 0);
        check("async_qd",  qd_m, 0);
        check("async_rr",  rr_m, 0);
        check("async_po",  po_m, 0);
        check("async_rv",  rv_m, 0);
        check("async_res", res_m, 0);
        run("diamond_rerun", 0, 3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
